// File: rtl/gpio_bank_if.sv
// CPU bus bundle for gpio_bank: strobes and address/data from the system
// decoder, registered read data and the two acknowledge pulses back.
interface gpio_bank_if #(
   parameter int width     = 8,
   parameter int size_addr = 4
);
   // read/write are single-cycle strobes sampled on posedge; every sampled
   // strobe is answered by exactly one ready_r/ready_w pulse in the next
   // cycle (no back-pressure), and data_out is valid while ready_r is high
   // and holds until the next sampled read.
   logic                 read;
   logic                 write;
   logic [size_addr-1:0] address;
   logic [width-1:0]     data_in;
   logic [width-1:0]     data_out;
   logic                 ready_r;
   logic                 ready_w;

   modport master (
      output read, write, address, data_in,
      input  data_out, ready_r, ready_w
   );

   modport slave (
      input  read, write, address, data_in,
      output data_out, ready_r, ready_w
   );
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: CHANNELS GPIO channels of WIDTH bits on the CPU bus.
// Per channel: OUT latch, DIR register, 2-flop synchronised IN view and
// sticky rising-edge FLAG (write-1-to-clear). irq is the registered OR of
// all flags. Channel c occupies bits [c*width +: width] of the pin vectors.
module gpio_bank #(
   parameter int width     = 8,
   parameter int channels  = 4,
   parameter int size_addr = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   gpio_bank_if.slave                bus,
   input  logic [channels*width-1:0] port_in,
   output logic [channels*width-1:0] port_out,
   output logic [channels*width-1:0] port_oe,
   output logic                      irq
);
   localparam int CW = size_addr - 2;
   localparam int NB = channels * width;

   logic [CW-1:0]      ch_idx;
   logic [1:0]         reg_sel;

   logic [NB-1:0]      out_r;
   logic [NB-1:0]      dir_r;
   logic [NB-1:0]      flag_r;
   logic [NB-1:0]      s1_r;
   logic [NB-1:0]      s2_r;
   logic [NB-1:0]      prev_r;
   logic [NB-1:0]      rise;
   logic [NB-1:0]      clr_mask;
   logic [channels-1:0] out_we;
   logic [channels-1:0] dir_we;
   logic [width-1:0]   rd_val;

   logic [width-1:0]   rd_data_q;
   logic               rd_ack_q;
   logic               wr_ack_q;
   logic               irq_q;

   assign ch_idx  = bus.address[size_addr-1:2];
   assign reg_sel = bus.address[1:0];

   // Only pins configured as inputs can raise a flag.
   assign rise = s2_r & ~prev_r & ~dir_r;

   // Address decode: read mux and per-channel write enables. A channel index
   // beyond the last channel matches nothing, so reads give 0 and writes drop.
   always_comb begin
      rd_val   = '0;
      out_we   = '0;
      dir_we   = '0;
      clr_mask = '0;
      for (int c = 0; c < channels; c++) begin
         if (ch_idx == CW'(c)) begin
            case (reg_sel)
               2'd0: rd_val = out_r[c*width +: width];
               2'd1: rd_val = dir_r[c*width +: width];
               2'd2: rd_val = s2_r[c*width +: width];
               default: rd_val = flag_r[c*width +: width];
            endcase
            if (bus.write) begin
               case (reg_sel)
                  2'd0: out_we[c] = 1'b1;
                  2'd1: dir_we[c] = 1'b1;
                  2'd3: clr_mask[c*width +: width] = bus.data_in;
                  default: ;
               endcase
            end
         end
      end
   end

   // Register file, synchronisers, sticky flags and bus acknowledges.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_r     <= '0;
         dir_r     <= '0;
         flag_r    <= '0;
         s1_r      <= '0;
         s2_r      <= '0;
         prev_r    <= '0;
         rd_data_q <= '0;
         rd_ack_q  <= 1'b0;
         wr_ack_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         s1_r     <= port_in;
         s2_r     <= s1_r;
         prev_r   <= s2_r;
         // A new edge beats a same-cycle W1C on the same bit.
         flag_r   <= (flag_r & ~clr_mask) | rise;
         irq_q    <= |flag_r;
         rd_ack_q <= bus.read;
         wr_ack_q <= bus.write;
         if (bus.read) begin
            rd_data_q <= rd_val;
         end
         for (int c = 0; c < channels; c++) begin
            if (out_we[c]) begin
               out_r[c*width +: width] <= bus.data_in;
            end
            if (dir_we[c]) begin
               dir_r[c*width +: width] <= bus.data_in;
            end
         end
      end
   end

   assign bus.data_out = rd_data_q;
   assign bus.ready_r  = rd_ack_q;
   assign bus.ready_w  = wr_ack_q;
   assign port_out     = out_r;
   assign port_oe      = dir_r;
   assign irq          = irq_q;
endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank (4 channels x 8 bits, 5 address bits so that an
// out-of-range channel can be addressed). A register-map model tracks what
// every output must be and is compared each cycle; directed steps also pin
// hand-computed literal values.
module tb_gpio_bank;
   logic        clk;
   logic        reset;
   logic [31:0] port_in;
   logic [31:0] port_out;
   logic [31:0] port_oe;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   gpio_bank_if #(.width(8), .size_addr(5)) bus ();

   gpio_bank #(.width(8), .channels(4), .size_addr(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .port_in  (port_in),
      .port_out (port_out),
      .port_oe  (port_oe),
      .irq      (irq)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   logic [7:0]  m_out  [4];
   logic [7:0]  m_dir  [4];
   logic [7:0]  m_flag [4];
   logic [31:0] pin_ago1, pin_ago2, pin_ago3;  // pins seen 1/2/3 edges ago
   logic [7:0]  exp_data;
   logic        exp_rr, exp_rw, exp_irq;
   bit          model_live = 0;

   always @(posedge clk) begin
      int         ch;
      int         rg;
      logic [7:0] rise;
      logic [7:0] clr;
      logic [7:0] rd;
      if (reset) begin
         for (int c = 0; c < 4; c++) begin
            m_out[c] = 8'h00; m_dir[c] = 8'h00; m_flag[c] = 8'h00;
         end
         pin_ago1 = '0; pin_ago2 = '0; pin_ago3 = '0;
         exp_data = 8'h00; exp_rr = 1'b0; exp_rw = 1'b0; exp_irq = 1'b0;
         model_live = 1;
      end else begin
         ch = int'(bus.address[4:2]);
         rg = int'(bus.address[1:0]);
         rd = 8'h00;
         if (ch < 4) begin
            if (rg == 0) rd = m_out[ch];
            else if (rg == 1) rd = m_dir[ch];
            else if (rg == 2) rd = pin_ago2[ch*8 +: 8];
            else rd = m_flag[ch];
         end
         if (bus.read) exp_data = rd;
         exp_rr  = bus.read;
         exp_rw  = bus.write;
         exp_irq = (m_flag[0] | m_flag[1] | m_flag[2] | m_flag[3]) != 8'h00;
         for (int c = 0; c < 4; c++) begin
            rise = pin_ago2[c*8 +: 8] & ~pin_ago3[c*8 +: 8] & ~m_dir[c];
            clr  = (bus.write && ch == c && rg == 3) ? bus.data_in : 8'h00;
            m_flag[c] = (m_flag[c] & ~clr) | rise;
         end
         if (bus.write && ch < 4 && rg == 0) m_out[ch] = bus.data_in;
         if (bus.write && ch < 4 && rg == 1) m_dir[ch] = bus.data_in;
         pin_ago3 = pin_ago2;
         pin_ago2 = pin_ago1;
         pin_ago1 = port_in;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] e_po, e_oe;
      if (model_live) begin
         for (int c = 0; c < 4; c++) begin
            e_po[c*8 +: 8] = m_out[c];
            e_oe[c*8 +: 8] = m_dir[c];
         end
         check("cyc_data_out", {24'h0, bus.data_out}, {24'h0, exp_data});
         check("cyc_ready_r", {31'h0, bus.ready_r}, {31'h0, exp_rr});
         check("cyc_ready_w", {31'h0, bus.ready_w}, {31'h0, exp_rw});
         check("cyc_irq", {31'h0, irq}, {31'h0, exp_irq});
         check("cyc_port_out", port_out, e_po);
         check("cyc_port_oe", port_oe, e_oe);
      end
   end

   // ---------------- driver tasks (called at negedge) ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_read(input logic [4:0] a, input logic [7:0] exp, input string nm);
      bus.read = 1'b1; bus.address = a;
      @(negedge clk);
      bus.read = 1'b0;
      check(nm, {24'h0, bus.data_out}, {24'h0, exp});
      check({nm, "_rdy"}, {31'h0, bus.ready_r}, 32'h1);
   endtask

   task automatic do_write(input logic [4:0] a, input logic [7:0] d);
      bus.write = 1'b1; bus.address = a; bus.data_in = d;
      @(negedge clk);
      bus.write = 1'b0;
      check("wr_ready_w", {31'h0, bus.ready_w}, 32'h1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      reset = 1'b1; port_in = '0;
      bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.data_in = '0;
      idle(2);
      reset = 1'b0;
      check("rst_port_out", port_out, 32'h0);
      check("rst_port_oe", port_oe, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_data_out", {24'h0, bus.data_out}, 32'h0);

      // every offset of every channel reads 0 after reset
      for (int a = 0; a < 16; a++) do_read(5'(a), 8'h00, "rst_read");

      // ch2 OUT / DIR
      do_write(5'h08, 8'hA5);
      check("ch2_pout", {24'h0, port_out[23:16]}, 32'hA5);
      do_write(5'h09, 8'hFF);
      check("ch2_poe", {24'h0, port_oe[23:16]}, 32'hFF);
      do_read(5'h08, 8'hA5, "ch2_out_rd");
      do_read(5'h09, 8'hFF, "ch2_dir_rd");

      // ch0 pin 3 rising edge
      port_in[3] = 1'b1;
      idle(3);
      check("edge_irq_t2", {31'h0, irq}, 32'h0);
      idle(1);
      check("edge_irq_t3", {31'h0, irq}, 32'h1);
      do_read(5'h02, 8'h08, "ch0_in_rd");
      do_read(5'h03, 8'h08, "ch0_flag_rd");
      do_write(5'h03, 8'h08);
      check("w1c_irq_still", {31'h0, irq}, 32'h1);
      idle(1);
      check("w1c_irq_low", {31'h0, irq}, 32'h0);
      do_read(5'h03, 8'h00, "ch0_flag_clr");

      // ch1 bit 0 as output: no flag, IN still follows the pin
      do_write(5'h05, 8'h01);
      port_in[8] = 1'b1;
      idle(3);
      do_read(5'h06, 8'h01, "ch1_in_rd");
      port_in[8] = 1'b0;
      idle(4);
      check("out_pin_irq", {31'h0, irq}, 32'h0);
      do_read(5'h07, 8'h00, "ch1_flag_rd");

      // W1C coinciding with a new edge on the same bit
      port_in[3] = 1'b0;
      idle(4);
      port_in[3] = 1'b1;
      idle(5);
      check("race_irq_pre", {31'h0, irq}, 32'h1);
      port_in[3] = 1'b0;
      idle(4);
      port_in[3] = 1'b1;
      idle(2);
      do_write(5'h03, 8'h08);
      idle(2);
      check("race_irq_hold", {31'h0, irq}, 32'h1);
      do_read(5'h03, 8'h08, "race_flag_rd");
      do_write(5'h03, 8'h08);
      idle(1);
      check("race_irq_low", {31'h0, irq}, 32'h0);

      // out-of-range channel 7
      do_read(5'h08, 8'hA5, "pre_oor_rd");
      do_read(5'h1C, 8'h00, "oor_rd");
      do_write(5'h1C, 8'hFF);
      do_write(5'h1D, 8'hFF);
      do_write(5'h1F, 8'hFF);
      do_read(5'h0C, 8'h00, "ch3_out_rd");
      do_read(5'h0D, 8'h00, "ch3_dir_rd");
      check("oor_pout", port_out, 32'h00A5_0000);
      check("oor_poe", port_oe, 32'h00FF_0100);

      // read and write together
      do_write(5'h00, 8'h3C);
      bus.read = 1'b1; bus.write = 1'b1; bus.address = 5'h00; bus.data_in = 8'hC3;
      @(negedge clk);
      bus.read = 1'b0; bus.write = 1'b0;
      check("rw_old_data", {24'h0, bus.data_out}, 32'h3C);
      check("rw_ready_r", {31'h0, bus.ready_r}, 32'h1);
      check("rw_ready_w", {31'h0, bus.ready_w}, 32'h1);
      do_read(5'h00, 8'hC3, "rw_new_rd");
      check("rw_pout", port_out, 32'h00A5_00C3);

      // reset mid-read, with pin 0 held high through reset
      port_in = 32'h0000_0001;
      bus.read = 1'b1; bus.address = 5'h08; reset = 1'b1;
      @(negedge clk);
      bus.read = 1'b0; reset = 1'b0;
      check("mid_rst_ready_r", {31'h0, bus.ready_r}, 32'h0);
      check("mid_rst_data", {24'h0, bus.data_out}, 32'h0);
      check("mid_rst_pout", port_out, 32'h0);
      check("mid_rst_poe", port_oe, 32'h0);
      check("mid_rst_irq", {31'h0, irq}, 32'h0);
      idle(3);
      do_read(5'h03, 8'h01, "held_pin_flag");
      check("held_pin_irq", {31'h0, irq}, 32'h1);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised successor to the single-register output port: CHANNELS independent GPIO channels of WIDTH bits each, on the memory-mapped CPU bus.
- Each channel has an output latch, a per-bit direction register, a synchronised input view and sticky rising-edge flags.
- The OR of all flags drives one interrupt line.
- The system decoder drives `read`/`write`, the low address bits and `data_in`, and selects `data_out`/`ready` when the block is addressed.

Parameters:
- `width`, 8: bits per channel; equals the bus data width.
- `channels`, 4: number of channels, 1..16.
- `size_addr`, 4: address bits; must be at least clog2(channels)+2.

Ports:
- `clk`  in  1  system clock; all logic rises on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `read`  in  1  bus read strobe, sampled on posedge.
- `write`  in  1  bus write strobe, sampled on posedge.
- `address`  in  size_addr  register address: [size_addr-1:2] = channel index, [1:0] = register.
- `data_in`  in  width  write data.
- `data_out`  out  width  read data, registered.
- `ready_r`  out  1  read acknowledge.
- `ready_w`  out  1  write acknowledge.
- `port_in`  in  channels*width  external pins; channel c occupies bits [c*width +: width]; asynchronous.
- `port_out`  out  channels*width  output latches, same packing.
- `port_oe`  out  channels*width  direction; 1 = output enable.
- `irq`  out  1  registered OR of all edge flags.

Behaviour:
- Register map per channel:
  - offset 0 OUT: R/W.
  - offset 1 DIR: R/W.
  - offset 2 IN: RO, reads the synchronised pins; writes are ignored.
  - offset 3 FLAG: reads the sticky rising-edge flags; a write clears each bit where `data_in` is 1 (write-1-to-clear).
- Reset (`reset` high at posedge) clears everything to 0: OUT, DIR, FLAG, both synchroniser stages, the previous-value register, `data_out`, `ready_r`, `ready_w`, `irq`.
- Reset has priority over any bus access in the same cycle. A transaction in progress when reset is applied is dropped, and no ready is issued for it.
- Read handshake:
  - `read` high at posedge N gives `data_out` = addressed register and `ready_r` = 1 after posedge N (one-cycle latency).
  - `ready_r` is a one-cycle pulse per sampled cycle of `read`; holding `read` high for k cycles yields k consecutive pulses.
  - `data_out` holds its last value when no read is sampled.
- Write handshake:
  - `write` high at posedge N updates the register at posedge N; `ready_w` = 1 for the following cycle.
  - `ready_w` pulses once per sampled cycle of `write`.
- `read` and `write` in the same cycle:
  - both take effect and both ready outputs pulse;
  - `data_out` returns the pre-write value.
- Out-of-range access (channel index >= channels):
  - a read returns 0;
  - a write is ignored;
  - the ready pulse is still issued, so the bus never hangs.
- `port_out` = OUT and `port_oe` = DIR, both directly from registers, so a write is visible on the pins one cycle after the write posedge.
- Input path:
  - s1 <= `port_in` and s2 <= s1, giving 2-flop synchronisation.
  - IN reads s2.
  - prev <= s2 every cycle.
- Edge detection:
  - An edge is s2 & ~prev & ~DIR; only bits configured as inputs flag.
  - A detected edge sets the FLAG bit at the same posedge that updates prev.
  - A pin rising before posedge t is in s1 after t, in s2 after t+1, sets FLAG at posedge t+2, and `irq` goes high after t+3.
- Same-cycle edge set and W1C clear on one FLAG bit: the set wins and the bit stays 1.
- A pin held high through reset is treated as a rising edge once reset is released (prev was cleared). Its FLAG bit sets at the third posedge after release.
- `irq` <= |(all FLAG bits); it drops one cycle after the last flag is cleared.
- No width arithmetic beyond the bit-wise ops above; all registers are exactly `width` bits.

Test Plan:
- Reset, then read every offset of every channel → all return 0; `irq` = 0; `port_out` and `port_oe` = 0; exactly one `ready_r` pulse per read.
- Write ch2 OUT = 8'hA5 and DIR = 8'hFF → `port_out`[23:16] = A5 and `port_oe`[23:16] = FF one cycle after each write; read back A5 / FF; `ready_w` pulses once per write.
- ch0 DIR = 0; drive `port_in`[3] 0→1 → IN reads 8'h08 from the third cycle on; FLAG0 = 8'h08; `irq` high at t+3; write FLAG0 = 8'h08 → FLAG0 = 0 and `irq` low one cycle later.
- Set ch1 DIR bit 0 = 1; pulse `port_in`[8] → no flag and `irq` stays 0; IN still reflects the pin.
- Time a W1C write of FLAG bit 3 to coincide with a new edge on the same bit → bit remains 1 and `irq` stays high.
- Read address 5'h1C (ch7) with channels = 4 → `data_out` = 0 with `ready_r` pulse; a write there changes no register. Then assert `read` and `write` to ch0 OUT together → both ready outputs pulse and `data_out` is the old value. Then assert reset mid-read → no `ready_r` and all outputs return to 0.
